// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and display FSM encoding.
// Default 640x480@60 raster, 24-bit RGB.
package vga_timing_pkg;

   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BACK  = 48;
   localparam int DEF_H_ACT   = 640;
   localparam int DEF_H_FRONT = 16;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BACK  = 33;
   localparam int DEF_V_ACT   = 480;
   localparam int DEF_V_FRONT = 10;
   localparam int DEF_DW      = 24;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FRM = 2'd1,
      RUN      = 2'd2
   } state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with sync, active-region
// and frame-boundary decodes.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BACK  = DEF_H_BACK,
   parameter int H_ACT   = DEF_H_ACT,
   parameter int H_FRONT = DEF_H_FRONT,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_ACT   = DEF_V_ACT,
   parameter int V_FRONT = DEF_V_FRONT
)(
   input  logic sclk,
   input  logic s_rst_n,
   output logic hs_c,
   output logic vs_c,
   output logic h_act,
   output logic v_act,
   output logic h_first,
   output logic v_first,
   output logic frame_end
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_SE  = HW'(H_SYNC);
   localparam logic [HW-1:0] H_A0  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_A1  = HW'(H_SYNC + H_BACK + H_ACT);
   localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_SE  = VW'(V_SYNC);
   localparam logic [VW-1:0] V_A0  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_A1  = VW'(V_SYNC + V_BACK + V_ACT);
   localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_end;
   logic          v_end;

   assign h_end = (h_cnt == H_END);
   assign v_end = (v_cnt == V_END);

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_end) begin
         h_cnt <= '0;
         v_cnt <= v_end ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign hs_c      = (h_cnt < H_SE);
   assign vs_c      = (v_cnt < V_SE);
   assign h_act     = (h_cnt >= H_A0) && (h_cnt < H_A1);
   assign v_act     = (v_cnt >= V_A0) && (v_cnt < V_A1);
   assign h_first   = (h_cnt == H_A0);
   assign v_first   = (v_cnt == V_A0);
   assign frame_end = h_end && v_end;

endmodule

// File: rtl/vga_rfifo_display.sv
// VGA display stage: waits for a filled read FIFO, then streams
// one pixel per active cycle starting on a frame boundary.
module vga_rfifo_display
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BACK  = DEF_H_BACK,
   parameter int H_ACT   = DEF_H_ACT,
   parameter int H_FRONT = DEF_H_FRONT,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_ACT   = DEF_V_ACT,
   parameter int V_FRONT = DEF_V_FRONT,
   parameter int DW      = DEF_DW
)(
   input  logic          sclk,
   input  logic          s_rst_n,
   input  logic          rfifo_rd_ready,
   input  logic [DW-1:0] rfifo_rd_data,
   output logic          rfifo_rd_en,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic          vga_de,
   output logic [DW-1:0] vga_rgb,
   output logic          frame_start
);

   state_t state;
   logic   hs_c, vs_c, h_act, v_act;
   logic   h_first, v_first, frame_end;
   logic   de_d1, hs_d1, vs_d1, fs_d1;

   vga_timing_gen #(
      .H_SYNC  (H_SYNC),
      .H_BACK  (H_BACK),
      .H_ACT   (H_ACT),
      .H_FRONT (H_FRONT),
      .V_SYNC  (V_SYNC),
      .V_BACK  (V_BACK),
      .V_ACT   (V_ACT),
      .V_FRONT (V_FRONT)
   ) u_timing (
      .sclk      (sclk),
      .s_rst_n   (s_rst_n),
      .hs_c      (hs_c),
      .vs_c      (vs_c),
      .h_act     (h_act),
      .v_act     (v_act),
      .h_first   (h_first),
      .v_first   (v_first),
      .frame_end (frame_end)
   );

   // RUN is sticky so a draining FIFO never tears a frame
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:     if (rfifo_rd_ready) state <= WAIT_FRM;
            WAIT_FRM: if (frame_end)      state <= RUN;
            RUN:      state <= RUN;
            default:  state <= IDLE;
         endcase
      end
   end

   assign rfifo_rd_en = (state == RUN) && h_act && v_act;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         de_d1 <= 1'b0;
         hs_d1 <= 1'b0;
         vs_d1 <= 1'b0;
         fs_d1 <= 1'b0;
      end else begin
         de_d1 <= rfifo_rd_en;
         hs_d1 <= hs_c;
         vs_d1 <= vs_c;
         fs_d1 <= rfifo_rd_en && h_first && v_first;
      end
   end

   // FIFO data for a stage-1 pixel is valid in this cycle
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         vga_de      <= 1'b0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_de      <= de_d1;
         vga_hsync   <= ~hs_d1;
         vga_vsync   <= ~vs_d1;
         vga_rgb     <= de_d1 ? rfifo_rd_data : '0;
         frame_start <= fs_d1;
      end
   end

endmodule
